// File: rtl/pipe_reg_skid_pkg.sv
// pipe_reg_skid_pkg: shared state encoding and occupancy helpers for the skid pipeline stage.
package pipe_reg_skid_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // The state encoding doubles as the held-entry count.
    function automatic logic [OCC_W-1:0] occ_of(input state_e s);
        return OCC_W'(s);
    endfunction

endpackage

// File: rtl/pipe_reg_skid_dffr_en.sv
// dffr_en: WIDTH-bit register with synchronous active-high reset and load enable.
module dffr_en #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            q_o <= RESET_VAL;
        else if (en_i)
            q_o <= d_i;
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: pipeline register stage with valid/ready handshake, flush and a 2-entry skid buffer.
// in_ready, out_valid and occupancy are decoded purely from the registered state.
module pipe_reg_skid
    import pipe_reg_skid_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               FLUSH_CLR = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    state_e           state_q, state_d;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, skid_q;
    logic             in_fire, out_fire;

    assign in_ready  = state_q != ST_TWO;
    assign out_valid = state_q != ST_EMPTY;
    assign occupancy = occ_of(state_q);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            main_en = FLUSH_CLR;
            main_d  = RESET_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    state_d = in_fire ? ST_ONE : ST_EMPTY;
                    main_en = in_fire;
                end
                ST_ONE: begin
                    main_en = in_fire & out_fire;
                    skid_en = in_fire & ~out_fire;
                    state_d = (in_fire & ~out_fire) ? ST_TWO :
                              (~in_fire & out_fire) ? ST_EMPTY : ST_ONE;
                end
                ST_TWO: begin
                    // Skid entry is always the younger one, so it refills main.
                    state_d = out_fire ? ST_ONE : ST_TWO;
                    main_en = out_fire;
                    main_d  = skid_q;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    dffr_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (out_data)
    );

    dffr_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (skid_en),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

endmodule
